vedic_mac_accumulator: RTL
==========================

Name: vedic_mac_accumulator

Overview:
- Downstream consumer of the 8x8 pipelined Vedic multiplier.
- Tracks the valid/last tags of operand pairs fed to the multiplier, delays them to match the multiplier latency, and accumulates the 16-bit products into a dot-product sum.
- Presents each completed sum on a one-entry valid/ready output register with a term count.

Parameters:
- PIPE_LAT, 3: multiplier latency in clk1 cycles from operand to product; legal range 1..8.
- ACC_W, 24: accumulator/result width; legal range 16..32.
- CNT_W, 10: term-counter width.

Ports:
- clk1  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented to the multiplier this cycle.
- in_last  input  1  qualifies in_valid; final term of the current dot product.
- in_ready  output  1  block accepts a term this cycle; the beat is taken when in_valid & in_ready.
- prod  input  16  multiplier z output.
- out_valid  output  1  result register holds an unconsumed sum.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  completed dot-product sum.
- out_count  output  CNT_W  number of terms in out_sum, modulo 2^CNT_W.
- out_ovf  output  1  sticky overflow flag for this sum; exists only with VEDIC_MAC_SATURATE_EN.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0, accumulator=0, term counter=0. All delay-line tags are cleared; state is ACCUM.
- Delay line: PIPE_LAT-deep shift of {acc_v, acc_l}. Its input is {in_valid&in_ready, in_last&in_valid&in_ready}. A beat accepted at cycle t appears as acc_v at cycle t+PIPE_LAT, aligned with its prod.
- Accumulate: on a clk1 edge with acc_v=1:
  - acc <= acc+prod (ACC_W, zero-extended prod); cnt <= cnt+1.
  - If acc_l=1: out_sum <= acc+prod, out_count <= cnt+1, out_valid <= 1, acc <= 0, cnt <= 0.
- Latency: for a last beat accepted at cycle t, out_valid is first high in cycle t+PIPE_LAT+1.
- Arithmetic: unsigned. Default build wraps modulo 2^ACC_W. out_count wraps modulo 2^CNT_W.
- State machine:
  - ACCUM: in_ready=1. An accepted beat with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0; remaining in-flight beats still accumulate. When the acc_l beat retires, go to HOLD.
  - HOLD: in_ready=0, out_valid=1. On out_valid & out_ready: out_valid <= 0, next state ACCUM.
- in_ready is combinational from state only; it must not depend on in_valid or out_ready.
- Single-beat dot product (in_valid & in_last in one cycle): out_sum=prod, out_count=1.
- Idle cycles (in_valid=0) between beats of one dot product insert bubbles; the sum is unaffected.
- out_sum and out_count stay stable while out_valid=1 and out_ready=0.
- prod is ignored whenever acc_v=0; X on prod then must not propagate.
- rst asserted in any state takes effect at that edge. In-flight tags are dropped, so products still in the multiplier pipeline are never accumulated. A held result is discarded.

Optional Feature:
- Macro: VEDIC_MAC_SATURATE_EN.
- Defined:
  - The accumulator saturates at 2^ACC_W-1 and stays there for the rest of the dot product.
  - out_ovf port exists. It is set with the result when any add in that dot product saturated, and is cleared when the next sum is loaded and on rst.
- Undefined: modulo wrap, no out_ovf port, no saturation logic.

Decomposition:
- Package vedic_mac_pkg holds:
  - PROD_W=16 constant;
  - state typedef {ACCUM, DRAIN, HOLD};
  - default ACC_W/CNT_W constants.
- Sub-module vedic_tag_delay: parameterised PIPE_LAT x 2-bit shift register with synchronous clear. Reused wherever multiplier sidebands need alignment.

Test Plan:
- Three-term product: (10,20), (15,30), (25,40) back-to-back, last on the third beat. Required: out_sum=1650, out_count=3, out_valid exactly PIPE_LAT+1 cycles after the third accept; in_ready=0 from the cycle after that accept until the handshake.
- Single term: 255x255 with last. Required: out_sum=65025, out_count=1. Hold out_ready=0 for 5 cycles: out_sum stays stable and in_ready stays 0. Then out_ready=1: in_ready=1 the next cycle.
- Overflow: 259 terms of 255x255 (16,841,475 true sum).
  - Default build: out_sum=64,259 (wrapped), out_count=259.
  - With VEDIC_MAC_SATURATE_EN: out_sum=16,777,215 and out_ovf=1; the next sum of 1x1 gives out_sum=1, out_ovf=0.
- Bubbles: beats (2,2), idle, idle, (3,3), idle, (4,4)+last. Required: out_sum=29, out_count=3.
- Reset mid-DRAIN: accept (100,110)+last, assert rst one cycle later. Required: out_valid never rises. Then the sequence (1,1)+last gives out_sum=1, out_count=1.
- Back-to-back dot products: (50,60)+last accepted, handshake, then immediately (75,85)+last. Required: sums 3000 then 6375, each out_count=1, no carry-over between them.

Source files
------------

// File: rtl/vedic_mac_pkg.sv
// rtl/vedic_mac_pkg.sv - shared constants and state type for the Vedic MAC accumulator
package vedic_mac_pkg;

  // Width of the 8x8 multiplier product
  localparam int PROD_W    = 16;

  // Default accumulator and term-counter widths
  localparam int DEF_ACC_W = 24;
  localparam int DEF_CNT_W = 10;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/vedic_tag_delay.sv
// rtl/vedic_tag_delay.sv - DEPTH-stage 2-bit sideband delay line with synchronous clear
module vedic_tag_delay #(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);

  logic [1:0] stage [DEPTH];

  // Shift tags one stage per cycle; clear drops everything in flight
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= 2'b00;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vedic_mac_accumulator.sv
// rtl/vedic_mac_accumulator.sv - dot-product accumulator behind the pipelined Vedic multiplier (option: VEDIC_MAC_SATURATE_EN)
module vedic_mac_accumulator
  import vedic_mac_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
`ifdef VEDIC_MAC_SATURATE_EN
  ,
  output logic              out_ovf
`endif
);

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic [1:0]       tag_out;
  logic             acc_v;
  logic             acc_l;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign accept = in_valid & in_ready;

  // Tags travel alongside the operands so acc_v lines up with the matching prod
  vedic_tag_delay #(.DEPTH(PIPE_LAT)) u_tag_delay (
    .clk     (clk1),
    .clr     (rst),
    .tag_in  ({accept, in_last & accept}),
    .tag_out (tag_out)
  );

  assign acc_v = tag_out[1];
  assign acc_l = tag_out[0];

`ifdef VEDIC_MAC_SATURATE_EN
  logic [ACC_W:0] sum_wide;
  logic           sat_hit;
  logic           ovf_run;

  assign sum_wide = {1'b0, acc} + (ACC_W+1)'(prod);
  assign sat_hit  = sum_wide[ACC_W];
  assign acc_sum  = sat_hit ? '1 : sum_wide[ACC_W-1:0];

  // Sticky saturation flag for the running sum, published with the result
  always_ff @(posedge clk1) begin
    if (rst) begin
      ovf_run <= 1'b0;
      out_ovf <= 1'b0;
    end else if (acc_v) begin
      if (acc_l) begin
        out_ovf <= ovf_run | sat_hit;
        ovf_run <= 1'b0;
      end else begin
        ovf_run <= ovf_run | sat_hit;
      end
    end
  end
`else
  assign acc_sum = acc + ACC_W'(prod);
`endif

  assign cnt_inc = cnt + CNT_W'(1);

  // Accumulate retired products; the last one loads the result register
  always_ff @(posedge clk1) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else if (acc_v) begin
      if (acc_l) begin
        out_sum   <= acc_sum;
        out_count <= cnt_inc;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt_inc;
      end
    end
  end

  // State register
  always_ff @(posedge clk1) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  // Next-state: stop accepting after the last beat, hold until handshake
  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nx = DRAIN;
      DRAIN:   if (acc_v && acc_l)    state_nx = HOLD;
      HOLD:    if (out_ready)         state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
  end

endmodule
